// File: rtl/cpu1_alarm_pkg.sv
// Shared definitions for the CPU1 set-alarm button controller:
// FSM state encoding, register map and EVENT bit positions.
package cpu1_alarm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_DEB_PRESS   = 3'd1,
      ST_PRESSED     = 3'd2,
      ST_LONG        = 3'd3,
      ST_DEB_RELEASE = 3'd4
   } alarm_state_t;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd1;
   localparam logic [1:0] ADDR_EVENT   = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   localparam int EV_PRESS   = 0;
   localparam int EV_RELEASE = 1;
   localparam int EV_LONG    = 2;
   localparam int EV_W       = 3;

   // The button counts as held from qualified press until qualified release.
   function automatic logic is_debounced_high(alarm_state_t s);
      return (s == ST_PRESSED) || (s == ST_LONG) || (s == ST_DEB_RELEASE);
   endfunction

endpackage

// File: rtl/cpu1_sync2.sv
// Two-flop synchronizer bringing the asynchronous button level into the clk domain.
module cpu1_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cpu1_alarm_button_ctrl.sv
// Set-alarm button controller: debounces the button, detects press/release/long
// press, and exposes level, sticky events and an interrupt over Avalon-MM.
module cpu1_alarm_button_ctrl
   import cpu1_alarm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int LONG_CYCLES     = 100000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        in_port,
   output logic        irq
);

   // LONG_CYCLES exceeds DEBOUNCE_CYCLES, so this width covers both terminal counts.
   localparam int               CNT_W     = $clog2(LONG_CYCLES);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic             raw_s;
   alarm_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic             long_flag;
   logic [EV_W-1:0]  irq_mask;
   logic [EV_W-1:0]  event_q;
   logic [EV_W-1:0]  ev_set;
   logic [EV_W-1:0]  ev_clr;
   logic             wr_en;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   cpu1_sync2 u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port),
      .q       (raw_s)
   );

   // Event conditions double as the FSM's qualified transitions, so both agree exactly.
   always_comb begin
      ev_set             = '0;
      ev_set[EV_PRESS]   = (state == ST_DEB_PRESS)   &&  raw_s && (cnt == DEB_LAST);
      ev_set[EV_RELEASE] = (state == ST_DEB_RELEASE) && !raw_s && (cnt == DEB_LAST);
      ev_set[EV_LONG]    = (state == ST_PRESSED)     &&  raw_s && (cnt == LONG_LAST);
   end

   // Shared counter saturates while a state persists and restarts on every change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         long_flag <= 1'b0;
      end else begin
         if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
         case (state)
            ST_IDLE: begin
               if (raw_s) begin
                  state <= ST_DEB_PRESS;
                  cnt   <= '0;
               end
            end
            ST_DEB_PRESS: begin
               if (!raw_s) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (ev_set[EV_PRESS]) begin
                  state <= ST_PRESSED;
                  cnt   <= '0;
               end
            end
            ST_PRESSED: begin
               if (!raw_s) begin
                  state <= ST_DEB_RELEASE;
                  cnt   <= '0;
               end else if (ev_set[EV_LONG]) begin
                  state     <= ST_LONG;
                  cnt       <= '0;
                  long_flag <= 1'b1;
               end
            end
            ST_LONG: begin
               if (!raw_s) begin
                  state <= ST_DEB_RELEASE;
                  cnt   <= '0;
               end
            end
            ST_DEB_RELEASE: begin
               // A bounce back high resumes the hold; a short press restarts long timing.
               if (raw_s) begin
                  state <= long_flag ? ST_LONG : ST_PRESSED;
                  cnt   <= '0;
               end else if (ev_set[EV_RELEASE]) begin
                  state     <= ST_IDLE;
                  cnt       <= '0;
                  long_flag <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign wr_en        = chipselect && !write_n;
   assign ev_clr       = (wr_en && (address == ADDR_EVENT)) ? writedata[EV_W-1:0] : '0;
   assign unused_wdata = ^writedata[31:EV_W];

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: begin
            rd_mux[0] = is_debounced_high(state);
            rd_mux[1] = raw_s;
         end
         ADDR_IRQMASK: rd_mux[EV_W-1:0] = irq_mask;
         ADDR_EVENT:   rd_mux[EV_W-1:0] = event_q;
         ADDR_STATUS: begin
            rd_mux[2:0] = state;
            rd_mux[3]   = long_flag;
         end
         default: rd_mux = '0;
      endcase
   end

   // Sticky events: a hardware set in the same cycle as a software clear wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         event_q  <= '0;
         readdata <= '0;
      end else begin
         if (wr_en && (address == ADDR_IRQMASK)) begin
            irq_mask <= writedata[EV_W-1:0];
         end
         event_q  <= (event_q & ~ev_clr) | ev_set;
         readdata <= rd_mux;
      end
   end

   assign irq = |(event_q & irq_mask);

endmodule

// File: tb/tb_cpu1_alarm_button_ctrl.sv
// Self-checking bench for the alarm button controller with short debounce/long timings;
// register reads go through an expected-value queue and are checked one cycle later.
module tb_cpu1_alarm_button_ctrl;
   import cpu1_alarm_pkg::*;

   localparam int DEB  = 4;
   localparam int LONG = 16;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        in_port;
   logic        irq;

   exp_t sb_q[$];
   int   check_count = 0;
   int   fail_count  = 0;

   cpu1_alarm_button_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LONG)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
      check_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(logic level);
      in_port = level;
   endtask

   task automatic busWrite(logic [1:0] a, logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic busRead(logic [1:0] a, string tag, logic [31:0] exp);
      exp_t e;
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      e.tag      = tag;
      e.exp      = exp;
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      checkOutput(e.tag, readdata, e.exp);
      chipselect = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 1'b0;
      tick(2);
      checkOutput("rst_readdata", readdata, 32'h0);
      checkOutput("rst_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;
      busRead(ADDR_STATUS,  "rst_status", 32'h0);
      busRead(ADDR_EVENT,   "rst_event",  32'h0);
      busRead(ADDR_IRQMASK, "rst_mask",   32'h0);
      busRead(ADDR_DATA,    "rst_data",   32'h0);

      busWrite(ADDR_IRQMASK, 32'hFFFF_FFFF);
      busRead(ADDR_IRQMASK, "mask_rw", 32'h7);
      busWrite(ADDR_STATUS, 32'hFFFF_FFFF);
      busRead(ADDR_STATUS, "status_ro", 32'h0);

      // Glitch shorter than the debounce window.
      applyStimulus(1'b1);
      tick(3);
      applyStimulus(1'b0);
      tick(10);
      busRead(ADDR_EVENT,  "glitch_event",  32'h0);
      busRead(ADDR_STATUS, "glitch_status", 32'h0);
      checkOutput("glitch_irq", {31'b0, irq}, 32'h0);

      // Clean press: event lands on the sixth edge after the first sampling edge.
      busWrite(ADDR_IRQMASK, 32'h1);
      applyStimulus(1'b1);
      tick(6);
      checkOutput("press_early_irq", {31'b0, irq}, 32'h0);
      tick(1);
      checkOutput("press_irq", {31'b0, irq}, 32'h1);
      busRead(ADDR_DATA,   "press_data",   32'h3);
      busRead(ADDR_EVENT,  "press_event",  32'h1);
      busRead(ADDR_STATUS, "press_status", 32'h2);

      // Long press: 16 cycles after PRESSED entry.
      busWrite(ADDR_IRQMASK, 32'h4);
      tick(11);
      checkOutput("long_early_irq", {31'b0, irq}, 32'h0);
      tick(1);
      checkOutput("long_irq", {31'b0, irq}, 32'h1);
      busRead(ADDR_STATUS, "long_status", 32'hB);
      busWrite(ADDR_IRQMASK, 32'h2);
      checkOutput("release_pre_irq", {31'b0, irq}, 32'h0);
      tick(5);
      applyStimulus(1'b0);
      tick(6);
      checkOutput("release_early_irq", {31'b0, irq}, 32'h0);
      tick(1);
      checkOutput("release_irq", {31'b0, irq}, 32'h1);
      busRead(ADDR_EVENT,  "event_all",   32'h7);
      busRead(ADDR_STATUS, "status_idle", 32'h0);
      busRead(ADDR_DATA,   "data_idle",   32'h0);

      busWrite(ADDR_EVENT, 32'h1);
      busRead(ADDR_EVENT, "w1c", 32'h6);

      // Clear of bit0 coincides with a new press event.
      applyStimulus(1'b1);
      tick(6);
      busWrite(ADDR_EVENT, 32'h1);
      busRead(ADDR_EVENT, "w1c_set_wins", 32'h7);
      busWrite(ADDR_EVENT, 32'h7);
      busRead(ADDR_EVENT, "w1c_all", 32'h0);
      busWrite(ADDR_IRQMASK, 32'h7);
      tick(12);
      checkOutput("pre_reset_irq", {31'b0, irq}, 32'h1);
      busRead(ADDR_STATUS, "pre_reset_status", 32'hB);

      // Reset while in LONG with the button still held.
      reset_n = 1'b0;
      #1;
      checkOutput("rst_long_readdata", readdata, 32'h0);
      checkOutput("rst_long_irq", {31'b0, irq}, 32'h0);
      tick(3);
      busRead(ADDR_STATUS, "rst_hold_status", 32'h0);
      reset_n = 1'b1;
      busWrite(ADDR_IRQMASK, 32'h1);
      tick(5);
      checkOutput("repress_early_irq", {31'b0, irq}, 32'h0);
      tick(1);
      checkOutput("repress_irq", {31'b0, irq}, 32'h1);
      busRead(ADDR_EVENT,  "repress_event",  32'h1);
      busRead(ADDR_STATUS, "repress_status", 32'h2);

      applyStimulus(1'b0);
      tick(10);
      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
